// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Definitions shared by the pipeline blocks that meet at the MEM/WB boundary.
//   - XLEN_DEF / AW_DEF : default data width and register index width.
//   - halt_state_e      : write-back halt FSM states (RUN, HALTED).
//   - HLT_OPCODE        : opcode of the halt instruction. The MEM/WB buffer
//                         decodes it into wb_hlt; the halt controller acts on it.
//   - next_count        : commit counter increment. It wraps modulo 2**32 and
//                         does not saturate.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_e;

    // All-ones major opcode is reserved as the halt instruction.
    localparam logic [6:0] HLT_OPCODE = 7'b111_1111;

    function automatic logic [31:0] next_count(input logic [31:0] cnt);
        return cnt + 32'd1;
    endfunction

endpackage : pipeline_pkg

// File: rtl/wb_regfile_halt_ctrl.sv
// -----------------------------------------------------------------------------
// wb_halt_ctrl
//   Halt state machine and committed-write counter for the write-back stage.
//   Once a halt instruction reaches WB, the block leaves RUN and stays in
//   HALTED until reset. The instruction that is in WB during the halt cycle
//   still commits, because run_en_o is derived from the current state.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous, active-high reset
//   hlt_i           in   halt instruction present in WB this cycle
//   commit_i        in   a register write commits at this edge (already gated)
//   run_en_o        out  1 while in RUN (combinational from the state register)
//   halted_o        out  registered, 1 once HALTED
//   commit_count_o  out  number of committed register writes, wraps at 2**32
// -----------------------------------------------------------------------------
module wb_halt_ctrl
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hlt_i,
    input  logic        commit_i,
    output logic        run_en_o,
    output logic        halted_o,
    output logic [31:0] commit_count_o
);

    halt_state_e state_q;
    logic        halted_q;
    logic [31:0] count_q;
    logic [31:0] count_d;

    assign count_d = next_count(count_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // commit_i is already qualified by run_en_o, so the counter
            // freezes on its own once HALTED.
            if (commit_i) begin
                count_q <= count_d;
            end
            case (state_q)
                RUN: begin
                    if (hlt_i) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    // Absorbing until reset. A repeated halt has no effect.
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign run_en_o       = (state_q == RUN);
    assign halted_o       = halted_q;
    assign commit_count_o = count_q;

endmodule : wb_halt_ctrl

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Consumer end of the MEM/WB pipeline register. The block selects the
//   write-back value, commits it into the architectural register file, and
//   serves two combinational ID-stage read ports plus one debug read port.
//   The halt FSM and commit counter are in wb_halt_ctrl.
//
//   Build option: define REGFILE_BYPASS_EN to add write-through on the ID
//   read ports. When a commit targets the register being read, id_rsN_data
//   returns wb_wdata in the same cycle. dbg_data is never bypassed. When the
//   macro is undefined, ID reads return the pre-write array value.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   wb_alu_out                  ALU result from MEM/WB
//   wb_data_mem_out             load data from MEM/WB
//   wb_rd_ind                   destination register index
//   wb_rd_indzero               1 = destination is x0 (write suppressed)
//   wb_memread                  1 = write back load data, 0 = ALU result
//   wb_regwrite                 write enable from MEM/WB
//   wb_hlt                      halt instruction present in WB
//   id_rs1_ind / id_rs2_ind     ID-stage source indices
//   id_rs1_data / id_rs2_data   source operand data (combinational)
//   dbg_ind / dbg_data          debug read port (combinational, no bypass)
//   wb_wdata                    selected write-back value, for EX forwarding
//   wb_commit                   a register write happens at the next edge
//   commit_count                number of committed register writes
//   halted                      registered, 1 once halted
// -----------------------------------------------------------------------------
module wb_regfile
    import pipeline_pkg::*;
#(
    parameter int              XLEN    = XLEN_DEF,
    parameter int              AW      = AW_DEF,
    parameter logic [XLEN-1:0] SP_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] wb_alu_out,
    input  logic [XLEN-1:0] wb_data_mem_out,
    input  logic [AW-1:0]   wb_rd_ind,
    input  logic            wb_rd_indzero,
    input  logic            wb_memread,
    input  logic            wb_regwrite,
    input  logic            wb_hlt,
    input  logic [AW-1:0]   id_rs1_ind,
    input  logic [AW-1:0]   id_rs2_ind,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    input  logic [AW-1:0]   dbg_ind,
    output logic [XLEN-1:0] dbg_data,
    output logic [XLEN-1:0] wb_wdata,
    output logic            wb_commit,
    output logic [31:0]     commit_count,
    output logic            halted
);

    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs_q [NREG];
    logic            run_en;

    // Write-back select and commit qualification
    assign wb_wdata  = wb_memread ? wb_data_mem_out : wb_alu_out;

    // The explicit index check protects x0 even when MEM/WB fails to flag it
    // through wb_rd_indzero.
    assign wb_commit = wb_regwrite & ~wb_rd_indzero
                     & (wb_rd_ind != '0) & run_en;

    // Register array. An in-flight write at the reset edge is discarded
    // because the reset branch takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (wb_commit) begin
            regs_q[wb_rd_ind] <= wb_wdata;
        end
    end

    // Array read with x0 forced to zero, independent of the array contents.
    function automatic logic [XLEN-1:0] array_rd(input logic [AW-1:0] idx);
        return (idx == '0) ? '0 : regs_q[idx];
    endfunction

`ifdef REGFILE_BYPASS_EN
    // wb_commit already excludes x0, so a matching index is always nonzero.
    function automatic logic [XLEN-1:0] id_rd(input logic [AW-1:0] idx);
        return (wb_commit && (idx == wb_rd_ind)) ? wb_wdata : array_rd(idx);
    endfunction
`else
    // No write-through. The ID stage stalls or forwards externally for the
    // cycle in which its source is being written.
    function automatic logic [XLEN-1:0] id_rd(input logic [AW-1:0] idx);
        return array_rd(idx);
    endfunction
`endif

    assign id_rs1_data = id_rd(id_rs1_ind);
    assign id_rs2_data = id_rd(id_rs2_ind);
    assign dbg_data    = array_rd(dbg_ind);

    // Halt FSM and commit counter
    wb_halt_ctrl u_halt_ctrl (
        .clk            (clk),
        .rst            (rst),
        .hlt_i          (wb_hlt),
        .commit_i       (wb_commit),
        .run_en_o       (run_en),
        .halted_o       (halted),
        .commit_count_o (commit_count)
    );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int          XLEN = 32;
    localparam int          AW   = 5;
    localparam logic [31:0] SP   = 32'h0000_8000;

    logic          clk;
    logic          rst;
    logic [31:0]   wb_alu_out, wb_data_mem_out;
    logic [4:0]    wb_rd_ind;
    logic          wb_rd_indzero, wb_memread, wb_regwrite, wb_hlt;
    logic [4:0]    id_rs1_ind, id_rs2_ind, dbg_ind;
    logic [31:0]   id_rs1_data, id_rs2_data, dbg_data, wb_wdata;
    logic          wb_commit;
    logic [31:0]   commit_count;
    logic          halted;

    wb_regfile #(.XLEN(XLEN), .AW(AW), .SP_INIT(SP)) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_alu_out      (wb_alu_out),
        .wb_data_mem_out (wb_data_mem_out),
        .wb_rd_ind       (wb_rd_ind),
        .wb_rd_indzero   (wb_rd_indzero),
        .wb_memread      (wb_memread),
        .wb_regwrite     (wb_regwrite),
        .wb_hlt          (wb_hlt),
        .id_rs1_ind      (id_rs1_ind),
        .id_rs2_ind      (id_rs2_ind),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .dbg_ind         (dbg_ind),
        .dbg_data        (dbg_data),
        .wb_wdata        (wb_wdata),
        .wb_commit       (wb_commit),
        .commit_count    (commit_count),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        regwrite;
        logic [4:0]  rd;
        logic        indzero;
        logic        memread;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        hlt;
        logic [4:0]  rs1;
        logic [4:0]  dbg;
        logic        exp_commit;
        logic        exp_halted;
    } vec_t;

    typedef struct {
        logic [31:0] count;
        logic        halted;
        logic [4:0]  rd;
        logic [31:0] val;
    } sb_t;

    vec_t        vecs[10];
    sb_t         sb[$];
    logic [31:0] m_regs[32];
    logic [31:0] m_count;
    logic        m_halted;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_regs[2] = SP;
        m_count   = 32'h0;
        m_halted  = 1'b0;
    endtask

    task automatic idle_inputs();
        wb_regwrite = 1'b0; wb_hlt = 1'b0; wb_memread = 1'b0;
        wb_rd_indzero = 1'b0; wb_rd_ind = 5'd0;
        wb_alu_out = 32'h0; wb_data_mem_out = 32'h0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_ind = i[4:0];
            #1;
            chk($sformatf("%s_dbg_x%0d", tag, i), dbg_data, m_regs[i]);
        end
        chk({tag, "_count"}, commit_count, m_count);
        chk({tag, "_halted"}, {31'b0, halted}, {31'b0, m_halted});
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0] wd, exp_rs1;
        logic        cm;
        sb_t         e;
        @(negedge clk);
        wb_regwrite = v.regwrite; wb_rd_ind = v.rd; wb_rd_indzero = v.indzero;
        wb_memread = v.memread; wb_alu_out = v.alu; wb_data_mem_out = v.mem;
        wb_hlt = v.hlt; id_rs1_ind = v.rs1; dbg_ind = v.dbg; id_rs2_ind = 5'd0;
        #1;
        wd = v.memread ? v.mem : v.alu;
        cm = v.regwrite && !v.indzero && (v.rd != 5'd0) && !m_halted;
        chk({tag, "_wdata"}, wb_wdata, wd);
        chk({tag, "_commit"}, {31'b0, wb_commit}, {31'b0, v.exp_commit});
        chk({tag, "_commit_model"}, {31'b0, wb_commit}, {31'b0, cm});
`ifdef REGFILE_BYPASS_EN
        exp_rs1 = (cm && v.rs1 == v.rd) ? wd : m_regs[v.rs1];
`else
        exp_rs1 = m_regs[v.rs1];
`endif
        chk({tag, "_rs1"}, id_rs1_data, exp_rs1);
        chk({tag, "_dbg"}, dbg_data, m_regs[v.dbg]);
        if (cm) begin
            m_regs[v.rd] = wd;
            m_count      = m_count + 32'd1;
        end
        if (v.hlt) m_halted = 1'b1;
        sb.push_back('{m_count, m_halted, v.rd, m_regs[v.rd]});
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0; wb_hlt = 1'b0;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s_sb: got empty queue, required one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_count"}, commit_count, e.count);
            chk({tag, "_halted"}, {31'b0, halted}, {31'b0, e.halted});
            chk({tag, "_halted_tbl"}, {31'b0, halted}, {31'b0, v.exp_halted});
            id_rs2_ind = e.rd;
            #1;
            chk({tag, "_rs2_after"}, id_rs2_data, e.val);
        end
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        id_rs1_ind = 5'd0; id_rs2_ind = 5'd0; dbg_ind = 5'd0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_state("reset");

        //          rw    rd     iz    mr    alu            mem            hlt   rs1    dbg    cm    hlt'
        vecs[0] = '{1'b1, 5'd5,  1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 5'd5,  5'd2,  1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd7,  1'b0, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 1'b0, 5'd5,  5'd5,  1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd6,  1'b1, 1'b0, 32'h0BAD_0BAD, 32'h0000_0000, 1'b0, 5'd6,  5'd7,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd8,  1'b0, 1'b0, 32'h8888_8888, 32'h0000_0000, 1'b0, 5'd8,  5'd8,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd3,  1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 5'd3,  5'd3,  1'b1, 1'b0};
        vecs[6] = '{1'b1, 5'd3,  1'b0, 1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0, 5'd3,  5'd3,  1'b1, 1'b0};
        vecs[7] = '{1'b1, 5'd9,  1'b0, 1'b0, 32'h0000_0011, 32'h0000_0000, 1'b1, 5'd9,  5'd9,  1'b1, 1'b1};
        vecs[8] = '{1'b1, 5'd9,  1'b0, 1'b0, 32'h0000_0022, 32'h0000_0000, 1'b0, 5'd9,  5'd9,  1'b0, 1'b1};
        vecs[9] = '{1'b1, 5'd10, 1'b0, 1'b0, 32'h0000_0033, 32'h0000_0000, 1'b1, 5'd10, 5'd3,  1'b0, 1'b1};

        for (int k = 0; k < 10; k++) apply_vec(vecs[k], $sformatf("v%0d", k));
        check_state("halted");

        // Reset while HALTED with a write presented: write dropped, back to RUN.
        @(negedge clk);
        wb_regwrite = 1'b1; wb_rd_ind = 5'd12; wb_alu_out = 32'h0000_0077;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        check_state("rst_halted");

        // A new write to x4 succeeds after reset.
        v = '{1'b1, 5'd4, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 5'd4, 5'd4, 1'b1, 1'b0};
        apply_vec(v, "x4_after_rst");

        // Reset mid-cycle during a running write: x13 dropped, x4 cleared.
        @(negedge clk);
        wb_regwrite = 1'b1; wb_rd_ind = 5'd13; wb_alu_out = 32'h0000_0099;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        check_state("rst_run");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the WB-stage bundle (ALU result, load data, rd index, memread, regwrite, hlt) and commits results into the architectural register file.
- Serves the two combinational read ports used by the ID stage, plus one debug read port.
- Owns the halt state machine that freezes architectural state after a halt instruction reaches WB.
- Sits between the MEM/WB buffer and the ID stage / top-level testbench.

Parameters:
- XLEN, 32, data width of registers and write-back data.
- AW, 5, register index width (2**AW registers; x0 hardwired zero).
- SP_INIT, 32'h0000_0000, reset value of x2 (stack pointer).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_alu_out  input  XLEN  ALU result from MEM/WB.
- wb_data_mem_out  input  XLEN  load data from MEM/WB.
- wb_rd_ind  input  AW  destination register index.
- wb_rd_indzero  input  1  1 = destination is x0 (write suppressed).
- wb_memread  input  1  1 = select load data, 0 = select ALU result.
- wb_regwrite  input  1  write enable from MEM/WB.
- wb_hlt  input  1  halt instruction present in WB this cycle.
- id_rs1_ind, id_rs2_ind  input  AW  ID-stage source indices.
- id_rs1_data, id_rs2_data  output  XLEN  source operand data (combinational).
- dbg_ind  input  AW  debug read index.
- dbg_data  output  XLEN  debug read data (combinational, no bypass).
- wb_wdata  output  XLEN  selected write-back value (combinational), for EX forwarding.
- wb_commit  output  1  1 = a register write is performed at the next edge (combinational).
- commit_count  output  32  number of committed register writes.
- halted  output  1  registered, 1 once HALTED.

Behaviour:
- Reset (async, rst=1):
  - x2 = SP_INIT; all other registers = 0.
  - commit_count = 0; halted = 0; state = RUN.
- wb_wdata = wb_memread ? wb_data_mem_out : wb_alu_out.
- wb_commit = wb_regwrite & ~wb_rd_indzero & (wb_rd_ind != 0) & (state == RUN).
- On posedge clk with wb_commit=1:
  - regs[wb_rd_ind] <= wb_wdata.
  - commit_count <= commit_count + 1. The counter wraps modulo 2**32 with no saturation.
- x0 reads always return 0. Writes to x0 are never performed, even if wb_rd_indzero=0 with index 0.
- Halt FSM, states RUN and HALTED:
  - RUN -> HALTED on posedge clk with wb_hlt=1.
  - HALTED is absorbing until rst.
  - halted output = (state == HALTED).
- Halt cycle: the WB entry present in the same cycle as wb_hlt=1 is still committed if wb_commit=1. All later entries are discarded.
- In HALTED: no register writes, commit_count frozen. Read ports and dbg port stay functional.
- wb_hlt asserted while already HALTED: no effect.
- Reset mid-operation: an in-flight write at the reset edge is discarded. The state returns to RUN.
- Read ports are combinational from the array. Same-cycle write/read behaviour is defined by the optional feature.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if wb_commit=1 and id_rsN_ind == wb_rd_ind (nonzero), id_rsN_data = wb_wdata in the same cycle (write-through). dbg_data is never bypassed.
- Undefined: id_rsN_data returns the pre-write array value. The ID stage must stall or forward externally for one cycle.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN and AW defaults.
  - Halt state enum {RUN, HALTED}.
  - hlt_inst opcode constant, so the MEM/WB buffer and this block agree.
- One sub-module, wb_halt_ctrl, holds the halt FSM plus commit_count. It outputs run_en, which gates wb_commit.
- Array, write mux and read/bypass logic stay in wb_regfile.

Test Plan:
- Reset check: assert rst mid-cycle, then read all 32 indices on dbg -> x2=SP_INIT, others 0, commit_count=0, halted=0.
- Basic write: regwrite=1, rd=5, memread=0, alu_out=32'hDEAD_BEEF -> next cycle dbg_ind=5 gives DEAD_BEEF; commit_count=1.
- Load select and x0 protection:
  - memread=1, data_mem_out=32'h1234_5678, rd=7 -> x7=12345678.
  - rd=0 with regwrite=1, wb_rd_indzero=0 -> x0 reads 0, count unchanged.
- Bypass: same-cycle write rd=3, value 32'hA5A5_A5A5, with id_rs1_ind=3 ->
  - id_rs1_data = A5A5A5A5 with REGFILE_BYPASS_EN.
  - Old value without it.
- Halt: wb_hlt=1 together with a write to x9=32'h11 -> x9=11 committed, halted=1 next cycle. A subsequent write to x9=32'h22 is ignored; count frozen.
- Reset while HALTED and during a write -> write dropped, halted=0, a new write to x4 succeeds.
